// File: rtl/fib_pkg.sv
// rtl/fib_pkg.sv - shared state encoding and default sizes for the Fibonacci sequence generator
package fib_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fib_state_t;

  localparam int FIB_WIDTH_DEF = 16;
  localparam int FIB_CNT_W_DEF = 8;

endpackage

// File: rtl/fib_seq_gen_if.sv
// rtl/fib_seq_gen_if.sv - control and output-stream signal bundle of fib_seq_gen
interface fib_seq_gen_if
  import fib_pkg::*;
#(
  parameter int WIDTH = FIB_WIDTH_DEF,
  parameter int CNT_W = FIB_CNT_W_DEF
) ();

  logic             start;
  logic [WIDTH-1:0] seed0;
  logic [WIDTH-1:0] seed1;
  logic [CNT_W-1:0] num_terms;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             busy;
  logic             done;
  logic             ovf;

  modport master (
    output start, seed0, seed1, num_terms, out_ready,
    input  out_valid, out_data, out_last, busy, done, ovf
  );

  modport slave (
    input  start, seed0, seed1, num_terms, out_ready,
    output out_valid, out_data, out_last, busy, done, ovf
  );

endinterface

// File: rtl/fib_step.sv
// rtl/fib_step.sv - next-term adder with overflow flag; FIB_SAT_EN selects saturation instead of wrap
module fib_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             a_ovf_i,
  input  logic             b_ovf_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             ovf_o
);

  logic [WIDTH:0] sum_full;

  assign sum_full = {1'b0, a_i} + {1'b0, b_i};
  // An overflowed operand taints every later term, even if this add does not carry.
  assign ovf_o    = sum_full[WIDTH] | a_ovf_i | b_ovf_i;

`ifdef FIB_SAT_EN
  assign sum_o = ovf_o ? {WIDTH{1'b1}} : sum_full[WIDTH-1:0];
`else
  assign sum_o = sum_full[WIDTH-1:0];
`endif

endmodule

// File: rtl/fib_seq_gen.sv
// rtl/fib_seq_gen.sv - streams a seeded Fibonacci sequence over valid/ready; FIB_SAT_EN (in fib_step) saturates terms
module fib_seq_gen
  import fib_pkg::*;
#(
  parameter int WIDTH = FIB_WIDTH_DEF,
  parameter int CNT_W = FIB_CNT_W_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  fib_seq_gen_if.slave  bus
);

  fib_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             a_ovf_q, a_ovf_d;
  logic             b_ovf_q, b_ovf_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] step_sum;
  logic             step_ovf;

  fib_step #(.WIDTH(WIDTH)) u_step (
    .a_i     (a_q),
    .b_i     (b_q),
    .a_ovf_i (a_ovf_q),
    .b_ovf_i (b_ovf_q),
    .sum_o   (step_sum),
    .ovf_o   (step_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      a_ovf_q <= 1'b0;
      b_ovf_q <= 1'b0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      a_ovf_q <= a_ovf_d;
      b_ovf_q <= b_ovf_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    a_ovf_d = a_ovf_q;
    b_ovf_d = b_ovf_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.seed0;
          b_d     = bus.seed1;
          a_ovf_d = 1'b0;
          b_ovf_d = 1'b0;
          rem_d   = bus.num_terms;
          ovf_d   = 1'b0;
          state_d = (bus.num_terms != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (bus.out_ready) begin
          // Shift the window forward; the sticky flag follows the term leaving on the bus.
          a_d     = b_q;
          a_ovf_d = b_ovf_q;
          b_d     = step_sum;
          b_ovf_d = step_ovf;
          rem_d   = rem_q - CNT_W'(1);
          ovf_d   = ovf_q | a_ovf_q;
          if (rem_q == CNT_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.out_valid = (state_q == RUN);
  assign bus.out_last  = (state_q == RUN) && (rem_q == CNT_W'(1));
  assign bus.out_data  = a_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_fib_seq_gen.sv
// tb/tb_fib_seq_gen.sv - self-checking bench for fib_seq_gen against an unbounded-integer Fibonacci model
module tb_fib_seq_gen;

  localparam int W  = 8;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fib_seq_gen_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  fib_seq_gen #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  longint unsigned exp_data[$];
  bit              exp_flag[$];
  bit              exp_ovf;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // True Fibonacci values; a term is flagged when its exact value no longer fits in W bits.
  task automatic build(input int s0, input int s1, input int n);
    longint unsigned p1, p2, t, lim, mask;
    bit f;
    exp_data.delete();
    exp_flag.delete();
    lim  = 64'd1 << W;
    mask = lim - 1;
    p1 = 0;
    p2 = 0;
    for (int k = 0; k < n; k++) begin
      if (k == 0)      t = longint'(s0);
      else if (k == 1) t = longint'(s1);
      else             t = p1 + p2;
      p2 = p1;
      p1 = t;
      f = (t >= lim);
`ifdef FIB_SAT_EN
      exp_data.push_back(f ? mask : t);
`else
      exp_data.push_back(t & mask);
`endif
      exp_flag.push_back(f);
    end
  endtask

  // mode 0: ready always 1, mode 1: ready 1,0,0,1 repeating, mode 2: random ready
  task automatic run_seq(input int s0, input int s1, input int n, input int mode, input int abort_at);
    int idx, cyc, budget;
    logic rdy;
    logic [3:0] pat;
    pat = 4'b1001;
    build(s0, s1, n);
    exp_ovf = 1'b0;
    @(negedge clk);
    bus.seed0     = W'(s0);
    bus.seed1     = W'(s1);
    bus.num_terms = CW'(n);
    bus.start     = 1'b1;
    bus.out_ready = 1'($urandom);
    @(posedge clk);
    idx = 0;
    cyc = 0;
    budget = 4 * n + 20;
    while (idx < n && idx != abort_at && cyc < budget) begin
      @(negedge clk);
      bus.start     = 1'($urandom);
      bus.seed0     = W'($urandom);
      bus.seed1     = W'($urandom);
      bus.num_terms = CW'($urandom);
      if (mode == 0)      rdy = 1'b1;
      else if (mode == 1) rdy = pat[cyc % 4];
      else                rdy = 1'($urandom);
      bus.out_ready = rdy;
      #1;
      chk("run_valid", bus.out_valid, 1);
      chk($sformatf("term%0d_data", idx), bus.out_data, exp_data[idx]);
      chk("run_last", bus.out_last, (idx == n - 1));
      chk("run_ovf", bus.ovf, exp_ovf);
      chk("run_busy", bus.busy, 1);
      chk("run_done", bus.done, 0);
      @(posedge clk);
      if (rdy) begin
        exp_ovf = exp_ovf | exp_flag[idx];
        idx++;
      end
      cyc++;
    end
    if (abort_at >= 0 && idx == abort_at) return;
    chk("seq_timeout_terms", idx, n);
    @(negedge clk);
    bus.start     = 1'($urandom);
    bus.out_ready = 1'($urandom);
    #1;
    chk("done_pulse", bus.done, 1);
    chk("done_busy", bus.busy, 1);
    chk("done_valid", bus.out_valid, 0);
    chk("done_ovf", bus.ovf, exp_ovf);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    chk("idle_busy", bus.busy, 0);
    chk("idle_done", bus.done, 0);
    chk("idle_valid", bus.out_valid, 0);
    chk("idle_ovf", bus.ovf, exp_ovf);
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.seed0     = '0;
    bus.seed1     = '0;
    bus.num_terms = '0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_last", bus.out_last, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_ovf", bus.ovf, 0);
    chk("rst_data", bus.out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_seq(0, 1, 10, 0, -1);
    run_seq(0, 1, 10, 1, -1);
    run_seq(0, 1, 16, 0, -1);
    chk("wrap_ovf_sticky", bus.ovf, 1);
    run_seq(0, 1, 3, 0, -1);
    run_seq(5, 7, 0, 2, -1);

    // Abort after three terms; the third (300) overflows, so ovf must be cleared by reset.
    run_seq(200, 100, 10, 0, 3);
    @(negedge clk);
    #1;
    chk("pre_rst_ovf", bus.ovf, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", bus.out_valid, 0);
    chk("midrst_last", bus.out_last, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_ovf", bus.ovf, 0);
    chk("midrst_data", bus.out_data, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("midrst_no_done", bus.done, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("post_rst_done", bus.done, 0);
    chk("post_rst_busy", bus.busy, 0);
    run_seq(0, 1, 10, 0, -1);

    for (int r = 0; r < 20; r++) begin
      run_seq(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
              int'($urandom_range(0, 30)), 2, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fib_seq_gen.md
# fib_seq_gen

Parametrised Fibonacci sequence generator, successor to the fixed 4-bit series block. It takes two seed terms and a term count, then streams the sequence one term per cycle over a valid/ready output interface. Overflow is tracked per emitted term. The block sits between a control register interface (start/seeds/count) and any downstream consumer of a streamed data word.

## Interface
Parameters:
- WIDTH, 16, bit width of seeds and emitted terms (≥ 2)
- CNT_W, 8, bit width of term count

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request a new sequence; sampled only when busy=0
- seed0  in  WIDTH  term 0, captured on accepted start
- seed1  in  WIDTH  term 1, captured on accepted start
- num_terms  in  CNT_W  number of terms to emit (0 allowed)
- out_valid  out  1  out_data holds a term
- out_ready  in  1  consumer accepts term when out_valid && out_ready
- out_data  out  WIDTH  current term
- out_last  out  1  qualifies the final term of the sequence
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse after sequence completes
- ovf  out  1  sticky: an emitted term exceeded WIDTH bits; cleared on accepted start

## Operation
- Reset: state IDLE; out_valid, out_last, busy, done, ovf, out_data all 0; internal a, b, a_ovf, b_ovf, remaining = 0.
- States: IDLE, RUN, DONE.
- IDLE: start=1 → capture a=seed0, b=seed1, a_ovf=b_ovf=0, remaining=num_terms, ovf←0; go RUN if num_terms≠0, else DONE.
- RUN: out_valid=1, out_data=a, out_last=(remaining==1). On handshake: a←b, a_ovf←b_ovf; b←sum[WIDTH-1:0], b_ovf←sum[WIDTH]|a_ovf|b_ovf where sum = a+b at WIDTH+1 bits; remaining←remaining−1; ovf←ovf|a_ovf (flag of the term being emitted). Handshake with remaining==1 → DONE.
- DONE: done=1, out_valid=0, for exactly one cycle → IDLE.
- Without handshake, out_data/out_last/out_valid are held stable. out_valid is never withdrawn before handshake.
- start is ignored while busy=1. Seed and count changes after capture have no effect.
- Wrap: terms are modulo 2^WIDTH. Once b_ovf is set, it propagates to all later terms.
- out_ready is ignored outside RUN.

## Timing
- Start sampled at edge T → busy=1 and out_valid=1 after T (first term visible in cycle T+1).
- Throughput: one term per cycle with out_ready held 1. n terms occupy cycles T+1..T+n.
- done is high in cycle T+n+1, with busy=1. busy=0 and start can be accepted from T+n+2.
- num_terms=0 → done in cycle T+1 and no valid output.
- ovf updates in the cycle after the handshake of the first overflowed term.
- rst_n low at any time → immediate return to reset values; the sequence is abandoned with no done pulse.

## Configuration
- FIB_SAT_EN defined: when sum[WIDTH]=1 or a/b is already saturated, b←all-ones instead of the wrapped sum. The saturated value persists for all later terms (all-ones + x saturates). ovf behaviour is unchanged.
- Not defined: modulo wrap as above.

## Structure
- Package fib_pkg contains:
  - state enum fib_state_t {IDLE, RUN, DONE}
  - default WIDTH/CNT_W constants
- One sub-module, fib_step: combinational a+b with carry out and optional saturation (FIB_SAT_EN). The FSM, registers and handshake stay in fib_seq_gen.

## Test plan
- Basic: WIDTH=16, seeds 0,1, num_terms=10, out_ready=1 → 0,1,1,2,3,5,8,13,21,34 on consecutive cycles; out_last with 34; done the next cycle; ovf=0.
- Backpressure: same stimulus, out_ready toggled 1,0,0,1 pattern → identical sequence; out_data stable during stalls; no term lost or duplicated.
- Overflow wrap: WIDTH=8, seeds 0,1, num_terms=16 → term 13 is 233; term 14 is 121 (377 mod 256); ovf rises after the term-14 handshake and stays 1; a new start clears it.
- Saturation (FIB_SAT_EN): same as the wrap test → terms 14 and 15 are both 255; ovf=1.
- Zero count / ignored start: num_terms=0 → done one cycle after start, out_valid never 1. start pulsed during RUN → no effect on the sequence.
- Reset mid-run: rst_n low after the 3rd term → all outputs 0 immediately; no done pulse; a fresh start behaves as in the basic test.
